// File: rtl/tcdm_bank_pkg.sv
// rtl/tcdm_bank_pkg.sv - shared LFSR constants and counter helper for the TCDM bank responder
package tcdm_bank_pkg;

  localparam int unsigned LfsrWidth = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [LfsrWidth-1:0] LfsrTaps = 16'hB400;
  localparam logic [LfsrWidth-1:0] LfsrDefaultSeed = 16'hACE1;

  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
    return {s[LfsrWidth-2:0], ^(s & LfsrTaps)};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_bank_lfsr.sv
// rtl/tcdm_bank_lfsr.sv - free-running 16-bit Fibonacci LFSR driving the grant throttle
module tcdm_bank_lfsr
  import tcdm_bank_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = LfsrDefaultSeed
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [LfsrWidth-1:0] state_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_o <= Seed;
    end else begin
      state_o <= lfsr_next(state_o);
    end
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - single-port TCDM bank with throttled grant and fixed-latency reads
module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 8,
  parameter int unsigned          Latency   = 1,
  parameter int unsigned          StallThr  = 0,
  parameter logic [LfsrWidth-1:0] LfsrSeed  = LfsrDefaultSeed
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   add_i,
  input  logic                   wen_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [31:0]            rd_cnt_o,
  output logic [31:0]            wr_cnt_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned Depth    = 2 ** AddrWidth;
  localparam logic [7:0]  ThrByte  = 8'(StallThr);

  if (Latency == 0 || Latency > 8) begin : gen_bad_latency
    $error("tcdm_bank_responder: Latency must be in 1..8");
  end
  if (DataWidth % 8 != 0) begin : gen_bad_width
    $error("tcdm_bank_responder: DataWidth must be a multiple of 8");
  end
  if (LfsrSeed == '0) begin : gen_bad_seed
    $error("tcdm_bank_responder: LfsrSeed must be nonzero");
  end
  if (StallThr > 255) begin : gen_bad_thr
    $error("tcdm_bank_responder: StallThr must be in 0..255");
  end

  logic [LfsrWidth-1:0] lfsr_q;
  logic                 stall;
  logic                 rd_fire;
  logic                 wr_fire;

  tcdm_bank_lfsr #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .state_o(lfsr_q)
  );

  // Grant depends only on the request and the throttle, never on address or data
  assign stall   = (lfsr_q[7:0] < ThrByte);
  assign gnt_o   = req_i & ~stall & ~rst_i;
  assign rd_fire = gnt_o & ~wen_i;
  assign wr_fire = gnt_o & wen_i;

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      for (int j = 0; j < NumBytes; j++) begin
        if (be_i[j]) begin
          mem_q[add_i][8*j +: 8] <= wdata_i[8*j +: 8];
        end
      end
    end
  end

  // Stage 0 lives in the low bits; each cycle everything shifts one stage toward the output.
  // Data of an empty stage is kept at zero so the last stage can drive rdata_o directly.
  logic [Latency-1:0]           vld_q;
  logic [Latency-1:0]           vld_d;
  logic [Latency*DataWidth-1:0] dat_q;
  logic [Latency*DataWidth-1:0] dat_d;

  always_comb begin
    vld_d                 = vld_q << 1;
    vld_d[0]              = rd_fire;
    dat_d                 = dat_q << DataWidth;
    dat_d[DataWidth-1:0]  = rd_fire ? mem_q[add_i] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign rvalid_o = vld_q[Latency-1];
  assign rdata_o  = dat_q[Latency*DataWidth-1 -: DataWidth];

  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_fire) begin
        rd_cnt_q <= sat_inc(rd_cnt_q);
      end
      if (wr_fire) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
      end
      if (req_i && !gnt_o) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb/tb_tcdm_bank_responder.sv - self-checking bench for tcdm_bank_responder
module tb_tcdm_bank_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int THR_A = 0;
  localparam int THR_B = 128;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wen;
  logic [7:0]  add;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [1:0]       gnt_w;
  logic [1:0]       rv_w;
  logic [1:0][31:0] rdata_w;
  logic [1:0][31:0] rdc_w;
  logic [1:0][31:0] wrc_w;
  logic [1:0][31:0] stc_w;

  tcdm_bank_responder #(
    .DataWidth(32), .AddrWidth(8), .Latency(LAT_A), .StallThr(THR_A), .LfsrSeed(16'hACE1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_w[0]), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rv_w[0]), .rdata_o(rdata_w[0]),
    .rd_cnt_o(rdc_w[0]), .wr_cnt_o(wrc_w[0]), .stall_cnt_o(stc_w[0])
  );

  tcdm_bank_responder #(
    .DataWidth(32), .AddrWidth(8), .Latency(LAT_B), .StallThr(THR_B), .LfsrSeed(16'hACE1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_w[1]), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rv_w[1]), .rdata_o(rdata_w[1]),
    .rd_cnt_o(rdc_w[1]), .wr_cnt_o(wrc_w[1]), .stall_cnt_o(stc_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one instance of state per DUT, advanced once per cycle
  int unsigned cyc;
  logic [15:0] m_lfsr [2];
  logic [31:0] m_mem  [2][256];
  logic [31:0] m_rd   [2];
  logic [31:0] m_wr   [2];
  logic [31:0] m_st   [2];
  bit          m_rv   [2][16];
  logic [31:0] m_rdat [2][16];

  logic [31:0] seen_a[$];
  int unsigned seen_cyc[$];
  int          rv_cnt_a;
  int          noreq_gnt;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int thr_of(input int k);
    return (k == 0) ? THR_A : THR_B;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 16'hACE1;
      m_rd[k] = 0;
      m_wr[k] = 0;
      m_st[k] = 0;
      for (int i = 0; i < 256; i++) m_mem[k][i] = 0;
      for (int i = 0; i < 16; i++) begin
        m_rv[k][i] = 0;
        m_rdat[k][i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    bit          eg;
    int unsigned slot;
    logic [31:0] w;
    bit          fb;
    if (rst) model_reset();
    slot = cyc % 16;
    if (rv_w[0] === 1'b1) begin
      seen_a.push_back(rdata_w[0]);
      seen_cyc.push_back(cyc);
      rv_cnt_a++;
    end
    if (!req && gnt_w !== 2'b00) noreq_gnt++;
    for (int k = 0; k < 2; k++) begin
      eg = req && !rst && (int'(m_lfsr[k][7:0]) >= thr_of(k));
      chk($sformatf("gnt_%0d", k), gnt_w[k], eg);
      chk($sformatf("rvalid_%0d", k), rv_w[k], m_rv[k][slot]);
      chk($sformatf("rdata_%0d", k), rdata_w[k], m_rv[k][slot] ? m_rdat[k][slot] : 32'd0);
      chk($sformatf("rd_cnt_%0d", k), rdc_w[k], m_rd[k]);
      chk($sformatf("wr_cnt_%0d", k), wrc_w[k], m_wr[k]);
      chk($sformatf("stall_cnt_%0d", k), stc_w[k], m_st[k]);
      m_rv[k][slot] = 0;
      m_rdat[k][slot] = 0;
      if (eg && wen) begin
        w = m_mem[k][add];
        for (int j = 0; j < 4; j++) if (be[j]) w[8*j +: 8] = wdata[8*j +: 8];
        m_mem[k][add] = w;
        m_wr[k] = bump(m_wr[k]);
      end else if (eg) begin
        m_rv[k][(cyc + lat_of(k)) % 16] = 1;
        m_rdat[k][(cyc + lat_of(k)) % 16] = m_mem[k][add];
        m_rd[k] = bump(m_rd[k]);
      end
      if (req && !eg) m_st[k] = bump(m_st[k]);
      fb = m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10];
      m_lfsr[k] = {m_lfsr[k][14:0], fb};
    end
    if (rst) model_reset();
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1; req = 1; wen = 0; add = 0; wdata = 0; be = 0;
    @(negedge clk);
    chk("reset_gnt", {62'd0, gnt_w}, 64'd0);
    chk("reset_rvalid", rv_w[0], 1'b0);
    chk("reset_rdata", rdata_w[0], 32'd0);
    chk("reset_counts", {rdc_w[0] | wrc_w[0] | stc_w[0]}, 32'd0);
    step();
    step();
    rst = 0; req = 0;
  endtask

  task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    step();
    req = 1; wen = w; add = a; wdata = d; be = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; rv_cnt_a = 0; noreq_gnt = 0;
    rst = 1; req = 0; wen = 0; add = 0; wdata = 0; be = 0;
    model_reset();

    // Write then read back at full enables; also pin the first LFSR steps
    do_reset();
    @(negedge clk);
    chk("lfsr_seed", dut_a.lfsr_q, 16'hACE1);
    access(1, 8'd5, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("lfsr_step1", dut_a.lfsr_q, 16'h59C3);
    chk("wr_gnt", gnt_w[0], 1'b1);
    access(0, 8'd5, 32'd0, 4'h0);
    @(negedge clk);
    chk("rd_gnt", gnt_w[0], 1'b1);
    for (int i = 1; i <= LAT_A; i++) begin
      step(); req = 0;
      @(negedge clk);
      chk($sformatf("lat_rvalid_%0d", i), rv_w[0], (i == LAT_A));
      if (i == LAT_A) chk("lat_rdata", rdata_w[0], 32'hDEADBEEF);
    end

    // Partial byte enables
    do_reset();
    access(1, 8'd3, 32'h11223344, 4'b0101);
    access(0, 8'd3, 32'd0, 4'h0);
    step(); req = 0;
    repeat (LAT_A - 1) step();
    @(negedge clk);
    chk("be_rdata", rdata_w[0], 32'h00220044);

    // Back-to-back reads, responses in order on consecutive cycles
    do_reset();
    for (int i = 0; i < 8; i++) access(1, 8'(i), 32'hA0 + i, 4'hF);
    for (int i = 0; i < 8; i++) begin
      access(0, 8'(i), 32'd0, 4'h0);
      if (i == 0) begin
        seen_a.delete();
        seen_cyc.delete();
      end
    end
    step(); req = 0;
    repeat (4) step();
    @(negedge clk);
    chk("b2b_count", seen_a.size(), 8);
    if (seen_a.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("b2b_data_%0d", i), seen_a[i], 32'hA0 + i);
      chk("b2b_span", seen_cyc[7] - seen_cyc[0], 7);
    end
    chk("b2b_rd_cnt", rdc_w[0], 32'd8);

    // Reset with a read in flight
    do_reset();
    access(1, 8'd9, 32'h55AA00FF, 4'hF);
    access(0, 8'd9, 32'd0, 4'h0);
    step(); req = 0;
    step(); rst = 1; rv_cnt_a = 0;
    step();
    step(); rst = 0;
    repeat (5) step();
    @(negedge clk);
    chk("rst_no_rvalid", rv_cnt_a, 0);
    access(0, 8'd9, 32'd0, 4'h0);
    step(); req = 0;
    repeat (LAT_A - 1) step();
    @(negedge clk);
    chk("rst_rvalid", rv_w[0], 1'b1);
    chk("rst_cleared", rdata_w[0], 32'd0);

    // Write counter saturation
    do_reset();
    step();
    force dut_a.wr_cnt_q = 32'hFFFF_FFFE;
    m_wr[0] = 32'hFFFF_FFFE;
    step();
    release dut_a.wr_cnt_q;
    req = 1; wen = 1; add = 8'd20; wdata = 32'h1; be = 4'hF;
    access(1, 8'd21, 32'h2, 4'hF);
    access(1, 8'd22, 32'h3, 4'hF);
    step(); req = 0;
    @(negedge clk);
    chk("wr_cnt_sat", wrc_w[0], 32'hFFFF_FFFF);

    // Throttled grants under a held request
    do_reset();
    step(); req = 1; wen = 0; add = 8'h10;
    repeat (1000) step();
    req = 0;
    @(negedge clk);
    chk("thr_sum", stc_w[1] + rdc_w[1], 32'd1000);
    chk("thr_range", (stc_w[1] >= 400 && stc_w[1] <= 600), 1'b1);
    chk("nothr_rd", rdc_w[0], 32'd1000);
    repeat (5) step();
    @(negedge clk);
    chk("no_gnt_without_req", noreq_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning the word width in bits (a multiple of 8).
REQ-002 SHALL have parameter AddrWidth, default 8, meaning the word address bits; depth is 2**AddrWidth words.
REQ-003 SHALL have parameter Latency, default 1, meaning the read latency in cycles from grant to response (legal range 1..8).
REQ-004 SHALL have parameter StallThr, default 0, meaning the grant-throttle threshold (0..255); 0 means never stall.
REQ-005 SHALL have parameter LfsrSeed, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_i, input, 1 bit: bank request (chip select).
REQ-009 SHALL have port gnt_o, output, 1 bit: request accepted this cycle.
REQ-010 SHALL have port add_i, input, AddrWidth bits: word address.
REQ-011 SHALL have port wen_i, input, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port wdata_i, input, DataWidth bits: write data.
REQ-013 SHALL have port be_i, input, DataWidth/8 bits: byte enables (writes only).
REQ-014 SHALL have port rvalid_o, output, 1 bit: read response valid.
REQ-015 SHALL have port rdata_o, output, DataWidth bits: read data.
REQ-016 SHALL have port rd_cnt_o, output, 32 bits: saturating count of granted reads.
REQ-017 SHALL have port wr_cnt_o, output, 32 bits: saturating count of granted writes.
REQ-018 SHALL have port stall_cnt_o, output, 32 bits: saturating count of cycles with req_i=1 and gnt_o=0.

Function
REQ-019 SHALL compute stall = (lfsr_q[7:0] < StallThr); gnt_o = req_i & ~stall, combinationally, with no dependence on add_i, wen_i or data.
REQ-020 SHALL advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle, independent of req_i.
REQ-021 SHALL update memory on a granted write in the grant cycle, for bytes with be_i[j]=1 only; other bytes keep their value.
REQ-022 SHALL sample mem[add_i] on a granted read in the grant cycle and return it with rvalid_o=1 exactly Latency cycles later.
REQ-023 SHALL make a write granted in cycle t visible to a read granted in cycle t+1 or later; a read and write never coincide (one port).
REQ-024 SHALL keep the read pipeline (Latency stages of valid+data) fully pipelined: one read per cycle is sustainable; responses return in grant order.
REQ-025 SHALL drive rdata_o to '0 whenever rvalid_o=0.
REQ-026 SHALL generate no response for writes.
REQ-027 SHALL make the counters increment by 1 per qualifying cycle and hold at 32'hFFFF_FFFF.
REQ-028 SHALL ensure that ungranted requests have no side effects; the requester holds them (the retry policy belongs to the initiator).

Reset
REQ-029 SHALL, while rst_i=1: set rvalid_o=0, rdata_o=0, all pipeline valid bits 0, counters 0, lfsr_q=LfsrSeed, and clear every memory word to 0.
REQ-030 SHALL discard reads in flight when rst_i is asserted mid-operation; no rvalid_o pulse follows deassertion.
REQ-031 SHALL keep gnt_o=0 while rst_i=1.

Structure
REQ-032 SHALL place the LFSR width, taps and default seed constants in the shared package tcdm_bank_pkg.
REQ-033 SHALL implement the LFSR as the sub-module tcdm_bank_lfsr (clk_i, rst_i, state_o); the memory array and read pipeline are inline.
REQ-034 SHALL assert at elaboration that Latency is in 1..8, DataWidth%8==0, and LfsrSeed!=0.

Verification
REQ-035 SHALL verify this case: StallThr=0, write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 -> gnt_o=1 both cycles; rvalid_o=1 with rdata_o=0xDEADBEEF exactly Latency cycles after the read grant.
REQ-036 SHALL verify this case: write 0x11223344 to addr 3 with be=4'b0101 after reset -> a subsequent read returns 0x00220044.
REQ-037 SHALL verify this case: Latency=3, back-to-back reads of addr 0..7 for 8 cycles -> 8 consecutive rvalid_o pulses in address order; rd_cnt_o=8.
REQ-038 SHALL verify this case: StallThr=128, req_i held for 1000 cycles -> stall_cnt_o+rd_cnt_o=1000, stall_cnt_o within 400..600, and gnt_o never 1 when req_i=0.
REQ-039 SHALL verify this case: issue a read, assert rst_i before Latency elapses -> no rvalid_o pulse, and a subsequent read of the previously written address returns 0.
REQ-040 SHALL verify this case: preload wr_cnt_o via force to 32'hFFFF_FFFE, then perform 3 writes -> wr_cnt_o=32'hFFFF_FFFF.
